reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/regfile_pkg.sv | 17 +
 rtl/reg_scoreboard.sv | 46 ++++
 rtl/reg_file_sb.sv | 76 +++++++
 tb/tb_reg_file_sb.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and the address-width helper for the scoreboarded register file.
package regfile_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_DEPTH = 16;

   // Smallest w with 2**w >= depth; usable in parameter expressions.
   function automatic int addr_width(input int depth);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < depth) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set by an issue mark, cleared by the matching write.
module reg_scoreboard
   import regfile_pkg::*;
#(
   parameter  int DEPTH    = DEF_DEPTH,
   parameter  int ZERO_REG = 1,
   localparam int AW       = addr_width(DEPTH)
) (
   input  logic          clk,
   input  logic          clear,
   input  logic          iss_valid,
   input  logic [AW-1:0] iss_addr,
   input  logic          clr_valid,
   input  logic [AW-1:0] clr_addr,
   input  logic [AW-1:0] a_addr,
   input  logic [AW-1:0] b_addr,
   output logic          a_busy,
   output logic          b_busy
);

   logic [DEPTH-1:0] busy_q, busy_d;
   logic [DEPTH-1:0] set_vec, clr_vec;

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (iss_valid) set_vec[iss_addr] = 1'b1;
      if (clr_valid) clr_vec[clr_addr] = 1'b1;
      if (ZERO_REG != 0) begin
         set_vec[0] = 1'b0;
         clr_vec[0] = 1'b0;
      end
      // Set after clear so a same-edge issue keeps the register busy.
      busy_d = (busy_q & ~clr_vec) | set_vec;
   end

   // A register being written this cycle is served by the bypass, so it is not busy.
   assign a_busy = busy_q[a_addr] & ~clr_vec[a_addr];
   assign b_busy = busy_q[b_addr] & ~clr_vec[b_addr];

   always_ff @(posedge clk or posedge clear) begin
      if (clear) busy_q <= '0;
      else       busy_q <= busy_d;
   end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with write bypass on every read port and a busy-bit scoreboard.
module reg_file_sb
   import regfile_pkg::*;
#(
   parameter  int WIDTH    = DEF_WIDTH,
   parameter  int DEPTH    = DEF_DEPTH,
   parameter  int ZERO_REG = 1,
   localparam int AW       = addr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [AW-1:0]    a_addr,
   input  logic [AW-1:0]    b_addr,
   output logic [WIDTH-1:0] a_data,
   output logic [WIDTH-1:0] b_data,
   output logic             a_busy,
   output logic             b_busy,
   output logic             stall,
   input  logic             c_load,
   input  logic [AW-1:0]    c_addr,
   input  logic [WIDTH-1:0] c_data,
   input  logic             iss_valid,
   input  logic [AW-1:0]    iss_addr,
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;

   function automatic logic writable(input logic [AW-1:0] addr);
      return (ZERO_REG == 0) || (addr != '0);
   endfunction

   function automatic logic [WIDTH-1:0] rd(input logic [AW-1:0]             addr,
                                           input logic [DEPTH-1:0][WIDTH-1:0] regs,
                                           input logic                      ld,
                                           input logic [AW-1:0]             waddr,
                                           input logic [WIDTH-1:0]          wdata);
      if (!writable(addr))             return '0;
      else if (ld && (waddr == addr)) return wdata;
      else                            return regs[addr];
   endfunction

   always_comb begin
      regs_d = regs_q;
      if (c_load && writable(c_addr)) regs_d[c_addr] = c_data;
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) regs_q <= '0;
      else       regs_q <= regs_d;
   end

   assign a_data   = rd(a_addr,   regs_q, c_load, c_addr, c_data);
   assign b_data   = rd(b_addr,   regs_q, c_load, c_addr, c_data);
   assign dbg_data = rd(dbg_addr, regs_q, c_load, c_addr, c_data);

   reg_scoreboard #(
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk       (clk),
      .clear     (clear),
      .iss_valid (iss_valid),
      .iss_addr  (iss_addr),
      .clr_valid (c_load),
      .clr_addr  (c_addr),
      .a_addr    (a_addr),
      .b_addr    (b_addr),
      .a_busy    (a_busy),
      .b_busy    (b_busy)
   );

   assign stall = a_busy | b_busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench: vector table on the default 16x16 file, hand sequences for clear and a 32x32 copy.
module tb_reg_file_sb;

   logic clk = 1'b0;
   logic clear = 1'b1;
   always #5 clk = ~clk;

   // 16-bit x 16-register instance
   logic [3:0]  a0_addr, b0_addr, c0_addr, i0_addr, d0_addr;
   logic [15:0] a0_data, b0_data, c0_data, d0_data;
   logic        a0_busy, b0_busy, stall0, c0_load, i0_valid;

   // 32-bit x 32-register instance
   logic [4:0]  a1_addr, b1_addr, c1_addr, i1_addr, d1_addr;
   logic [31:0] a1_data, b1_data, c1_data, d1_data;
   logic        a1_busy, b1_busy, stall1, c1_load, i1_valid;

   reg_file_sb dut0 (
      .clk(clk), .clear(clear), .a_addr(a0_addr), .b_addr(b0_addr),
      .a_data(a0_data), .b_data(b0_data), .a_busy(a0_busy), .b_busy(b0_busy),
      .stall(stall0), .c_load(c0_load), .c_addr(c0_addr), .c_data(c0_data),
      .iss_valid(i0_valid), .iss_addr(i0_addr), .dbg_addr(d0_addr), .dbg_data(d0_data)
   );

   reg_file_sb #(.WIDTH(32), .DEPTH(32)) dut1 (
      .clk(clk), .clear(clear), .a_addr(a1_addr), .b_addr(b1_addr),
      .a_data(a1_data), .b_data(b1_data), .a_busy(a1_busy), .b_busy(b1_busy),
      .stall(stall1), .c_load(c1_load), .c_addr(c1_addr), .c_data(c1_data),
      .iss_valid(i1_valid), .iss_addr(i1_addr), .dbg_addr(d1_addr), .dbg_data(d1_data)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        ld;
      logic [3:0]  ca;
      logic [15:0] cd;
      logic        iv;
      logic [3:0]  ia;
      logic [3:0]  aa, ba, da;
      logic [15:0] ea, eb, ed;
      logic        eab, ebb;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic ld, input logic [3:0] ca, input logic [15:0] cd,
                               input logic iv, input logic [3:0] ia,
                               input logic [3:0] aa, input logic [3:0] ba, input logic [3:0] da,
                               input logic [15:0] ea, input logic [15:0] eb, input logic [15:0] ed,
                               input logic eab, input logic ebb);
      vec_t v;
      v.ld = ld; v.ca = ca; v.cd = cd; v.iv = iv; v.ia = ia;
      v.aa = aa; v.ba = ba; v.da = da;
      v.ea = ea; v.eb = eb; v.ed = ed; v.eab = eab; v.ebb = ebb;
      return v;
   endfunction

   task automatic idle0();
      c0_load = 1'b0; c0_addr = '0; c0_data = '0; i0_valid = 1'b0; i0_addr = '0;
   endtask

   task automatic idle1();
      c1_load = 1'b0; c1_addr = '0; c1_data = '0; i1_valid = 1'b0; i1_addr = '0;
   endtask

   initial begin
      idle0(); idle1();
      a0_addr = '0; b0_addr = '0; d0_addr = '0;
      a1_addr = '0; b1_addr = '0; d1_addr = '0;

      // Reset state: every address reads zero, nothing stalls.
      #1;
      for (int i = 0; i < 32; i++) begin
         a0_addr = 4'(i); b0_addr = 4'(15 - (i % 16)); d0_addr = 4'(i);
         a1_addr = 5'(i); b1_addr = 5'(31 - i);       d1_addr = 5'(i);
         #0.1;
         if (i < 16) begin
            chk($sformatf("rst0_a[%0d]", i), 32'(a0_data), 32'h0);
            chk($sformatf("rst0_b[%0d]", i), 32'(b0_data), 32'h0);
            chk($sformatf("rst0_dbg[%0d]", i), 32'(d0_data), 32'h0);
            chk($sformatf("rst0_stall[%0d]", i), 32'(stall0), 32'h0);
         end
         chk($sformatf("rst1_a[%0d]", i), a1_data, 32'h0);
         chk($sformatf("rst1_dbg[%0d]", i), d1_data, 32'h0);
         chk($sformatf("rst1_stall[%0d]", i), 32'(stall1), 32'h0);
      end
      @(negedge clk);
      clear = 1'b0;

      tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 3, 5, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(1, 3, 16'h00A5, 0, 0, 3, 5, 3, 16'h00A5, 16'h0000, 16'h00A5, 0, 0));
      tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 3, 0, 3, 16'h00A5, 16'h0000, 16'h00A5, 0, 0));
      tbl.push_back(mk(1, 0, 16'hFFFF, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 3, 0, 16'h0000, 16'h00A5, 16'h0000, 0, 0));
      tbl.push_back(mk(0, 0, 16'h0000, 1, 5, 5, 5, 5, 16'h0000, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 3, 5, 5, 16'h00A5, 16'h0000, 16'h0000, 0, 1));
      tbl.push_back(mk(1, 5, 16'h0042, 0, 0, 5, 5, 5, 16'h0042, 16'h0042, 16'h0042, 0, 0));
      tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 5, 5, 3, 16'h0042, 16'h0042, 16'h00A5, 0, 0));
      tbl.push_back(mk(1, 7, 16'h1234, 1, 7, 7, 3, 7, 16'h1234, 16'h00A5, 16'h1234, 0, 0));
      tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 7, 3, 7, 16'h1234, 16'h00A5, 16'h1234, 1, 0));
      tbl.push_back(mk(1, 9, 16'hBEEF, 0, 0, 9, 7, 9, 16'hBEEF, 16'h1234, 16'hBEEF, 0, 1));
      tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 9, 7, 9, 16'hBEEF, 16'h1234, 16'hBEEF, 0, 1));
      tbl.push_back(mk(0, 0, 16'h0000, 1, 7, 7, 9, 0, 16'h1234, 16'hBEEF, 16'h0000, 1, 0));
      tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 7, 7, 7, 16'h1234, 16'h1234, 16'h1234, 1, 1));
      tbl.push_back(mk(1, 7, 16'h5555, 0, 0, 7, 7, 7, 16'h5555, 16'h5555, 16'h5555, 0, 0));
      tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 7, 0, 7, 16'h5555, 16'h0000, 16'h5555, 0, 0));
      tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0));
      tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         c0_load = tbl[i].ld; c0_addr = tbl[i].ca; c0_data = tbl[i].cd;
         i0_valid = tbl[i].iv; i0_addr = tbl[i].ia;
         a0_addr = tbl[i].aa; b0_addr = tbl[i].ba; d0_addr = tbl[i].da;
         #1;
         chk($sformatf("v%0d_a_data", i), 32'(a0_data), 32'(tbl[i].ea));
         chk($sformatf("v%0d_b_data", i), 32'(b0_data), 32'(tbl[i].eb));
         chk($sformatf("v%0d_dbg", i), 32'(d0_data), 32'(tbl[i].ed));
         chk($sformatf("v%0d_a_busy", i), 32'(a0_busy), 32'(tbl[i].eab));
         chk($sformatf("v%0d_b_busy", i), 32'(b0_busy), 32'(tbl[i].ebb));
         chk($sformatf("v%0d_stall", i), 32'(stall0), 32'(tbl[i].eab | tbl[i].ebb));
         @(negedge clk);
      end
      idle0();

      // Mark 2 and 9 busy on both instances; dut1 also gets data in 9 and 20.
      c1_load = 1'b1; c1_addr = 5'd9; c1_data = 32'hDEADBEEF; i0_valid = 1'b1; i0_addr = 4'd2;
      @(negedge clk);
      c1_addr = 5'd20; c1_data = 32'h0BADF00D; i1_valid = 1'b1; i1_addr = 5'd2;
      i0_addr = 4'd9;
      @(negedge clk);
      idle1(); i1_valid = 1'b1; i1_addr = 5'd9;
      idle0();
      @(negedge clk);
      idle1();
      a0_addr = 4'd2; b0_addr = 4'd9; d0_addr = 4'd3;
      a1_addr = 5'd2; b1_addr = 5'd9; d1_addr = 5'd20;
      #1;
      chk("pre_clr0_a_busy", 32'(a0_busy), 32'h1);
      chk("pre_clr0_b_busy", 32'(b0_busy), 32'h1);
      chk("pre_clr0_b_data", 32'(b0_data), 32'h0000BEEF);
      chk("pre_clr1_a_busy", 32'(a1_busy), 32'h1);
      chk("pre_clr1_b_busy", 32'(b1_busy), 32'h1);
      chk("pre_clr1_b_data", b1_data, 32'hDEADBEEF);
      chk("pre_clr1_dbg", d1_data, 32'h0BADF00D);

      // Clear mid-cycle, away from any edge.
      #2 clear = 1'b1;
      #1;
      chk("clr0_a_busy", 32'(a0_busy), 32'h0);
      chk("clr0_b_busy", 32'(b0_busy), 32'h0);
      chk("clr0_stall", 32'(stall0), 32'h0);
      chk("clr0_b_data", 32'(b0_data), 32'h0);
      chk("clr0_dbg", 32'(d0_data), 32'h0);
      chk("clr1_stall", 32'(stall1), 32'h0);
      chk("clr1_b_data", b1_data, 32'h0);
      chk("clr1_dbg", d1_data, 32'h0);

      // Writes and issue marks during clear are discarded, but the bypass still shows c_data.
      c0_load = 1'b1; c0_addr = 4'd4; c0_data = 16'h7777; i0_valid = 1'b1; i0_addr = 4'd4;
      a0_addr = 4'd4;
      #1;
      chk("clr_bypass", 32'(a0_data), 32'h00007777);
      chk("clr_bypass_busy", 32'(a0_busy), 32'h0);
      @(negedge clk);
      clear = 1'b0;
      idle0();
      #1;
      chk("clr_discard_data", 32'(a0_data), 32'h0);
      chk("clr_discard_busy", 32'(a0_busy), 32'h0);

      // First update after clear lands on the next rising edge.
      c0_load = 1'b1; c0_addr = 4'd4; c0_data = 16'h1111;
      @(negedge clk);
      idle0();
      #1;
      chk("post_clr_write", 32'(a0_data), 32'h00001111);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
